voq_scheduler: RTL
==================

# voq_scheduler

Crossbar scheduler for the switch fabric. It takes a per-slot snapshot of VOQ occupancy from every ingress block and computes a conflict-free ingress→egress matching using round-robin request/grant/accept (iSLIP). It drives each ingress block's `sched_sel` and `sched_done` to say which VOQ to dequeue in the coming slot. It sits between the ingress blocks and the crossbar/egress stage, one instance per switch.

## Interface
- `PORTS`, default 4: number of ingress ports and number of egress ports (square crossbar). The RTL is generic; verification uses 4.
- `ITERS`, default 2: number of grant/accept iterations per scheduling epoch, ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sched_start`  in  1: one-cycle request to run an epoch; honoured only in IDLE.
- `voq_nonempty`  in  PORTS*PORTS: bit [i*PORTS+j] is set when ingress i holds at least one packet for egress j.
- `sched_sel`  out  PORTS*PORTS: field [i*PORTS +: PORTS] is a one-hot egress select for ingress i; all-zero means no grant.
- `sched_done`  out  1: one-cycle pulse when `sched_sel` has just been updated.
- `busy`  out  1: high while an epoch is in progress.

## Operation
- FSM states: IDLE, GRANT, ACCEPT.
  - IDLE with `sched_start`=1: latch `voq_nonempty` into `req`, clear the match vectors (`in_matched`, `out_matched`, `match`), set iteration count to 0, go to GRANT.
  - GRANT → ACCEPT, always.
  - ACCEPT → GRANT if the iteration count is below ITERS-1 (then increment the count); otherwise → IDLE.
- `req` is a snapshot. Changes on `voq_nonempty` after the start edge have no effect on the current epoch.
- Round-robin pointers:
  - `gptr[j]`, one per egress, is log2(PORTS) bits.
  - `aptr[i]`, one per ingress, is log2(PORTS) bits.
  - Both reset to 0.
- GRANT phase: each unmatched egress j picks the first unmatched ingress i with `req[i][j]`, searching i = `gptr[j]`, `gptr[j]`+1, … mod PORTS. The resulting grant matrix is registered.
- ACCEPT phase: each unmatched ingress i that holds grants picks the first granting egress j, searching from `aptr[i]` mod PORTS. It sets `match[i]`=onehot(j) and marks both i and j matched.
- Pointer update happens in the first iteration only, and only for accepted pairs (i,j): `aptr[i]` <= (j+1) mod PORTS and `gptr[j]` <= (i+1) mod PORTS. Unaccepted grants leave pointers unchanged.
- A pair matched in any iteration is final. Later iterations only fill unmatched ports.
- Completion is the final ACCEPT edge. It registers `sched_sel` <= the complete match, including accepts made on that same edge, and sets `sched_done`<=1.
- `sched_sel` holds its value until the next completion.
- Invariant: every `sched_sel` field is one-hot or zero, and no egress bit is set in two fields.
- An all-zero `req` still runs the full epoch and produces all-zero `sched_sel` with a `sched_done` pulse.

## Timing
- Reset values: `sched_sel`=0, `sched_done`=0, `busy`=0, state IDLE, all pointers 0.
- `sched_start` is sampled at edge E0. `busy` is high from after E0 through the completion edge E0+2*ITERS and is low after it.
- `sched_done` is high for exactly the cycle after edge E0+2*ITERS (cycle E0+4 for ITERS=2). `sched_sel` is valid in that same cycle.
- `sched_start` while `busy`=1 is ignored; it is not queued.
- `sched_start` during the `sched_done` cycle is accepted, because the FSM is in IDLE. Back-to-back epochs therefore repeat every 2*ITERS+1 cycles.
- Reset asserted mid-epoch aborts immediately:
  - no `sched_done` pulse;
  - `sched_sel` is forced to 0;
  - pointers return to 0.

## Test plan
All scenarios use PORTS=4, ITERS=2.
1. Reset: hold `rst_n`=0 and toggle inputs → `sched_sel`=0, `sched_done`=0, `busy`=0. Release, then start with `voq_nonempty`=0 → `sched_done` pulse at E0+4 with `sched_sel`=0.
2. Single request, bit 9 (ingress 2→egress 1), start → at E0+4 `sched_sel`=0x0200 (ingress 2 field = 0010), all other fields 0. Afterwards `gptr[1]`=3 and `aptr[2]`=2.
3. Egress hotspot: `voq_nonempty` bits 0,4,8,12 (all ingress→egress 0), four consecutive epochs → the egress-0 winner is ingress 0, 1, 2, 3 in that order. The losers' fields are 0.
4. Full request matrix (0xFFFF) after reset:
   - epoch 1 → ingress0=0001, ingress1=0010, ingress2=0, ingress3=0 (`sched_sel`=0x0021);
   - epoch 2 → ingress0=0010, ingress1=0001, ingress2=0100, ingress3=0 (`sched_sel`=0x0412).
5. Pulse `sched_start` at E0+2 while busy, and change `voq_nonempty` to 0 at E0+1 → exactly one `sched_done`, and the result matches the E0 snapshot. A start in the `sched_done` cycle launches a new epoch, with its done at +5 cycles.
6. Assert `rst_n`=0 at E0+2 for one cycle → no `sched_done`, and `sched_sel`=0. A fresh epoch then behaves exactly like epoch 1 of scenario 4.

Source files
------------

// File: rtl/voq_scheduler.sv
// voq_scheduler: iSLIP crossbar scheduler. Each epoch snapshots VOQ occupancy
// and runs ITERS rounds of round-robin grant/accept to build a conflict-free
// ingress->egress matching, then publishes it on sched_sel with a sched_done
// pulse.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   sched_start      one-cycle epoch request, honoured only in IDLE
//   voq_nonempty     bit [i*PORTS+j]: ingress i holds traffic for egress j
//   sched_sel        field [i*PORTS +: PORTS]: one-hot egress for ingress i, 0 = none
//   sched_done       one-cycle pulse when sched_sel has just been updated
//   busy             high while an epoch is in progress
//   fsm_state        current FSM state (IDLE=0, GRANT=1, ACCEPT=2) for observation
//
// Handshake: sched_start is a single-cycle request with no ready; it is
// consumed when busy is low and dropped (not queued) when busy is high.
module voq_scheduler #(
  parameter int PORTS = 4,
  parameter int ITERS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sched_start,
  input  logic [PORTS*PORTS-1:0]   voq_nonempty,
  output logic [PORTS*PORTS-1:0]   sched_sel,
  output logic                     sched_done,
  output logic                     busy,
  output logic [1:0]               fsm_state
);

  localparam int NN = PORTS * PORTS;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACCEPT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [NN-1:0]     req, match, grant, grant_nxt, accept;
  logic [PORTS-1:0]  in_matched, out_matched, acc_in, acc_out;
  logic [CW-1:0]     iter;
  logic [PW-1:0]     gptr [PORTS];
  logic [PW-1:0]     aptr [PORTS];
  logic              last_iter;

  assign last_iter = (iter == CW'(ITERS - 1));

  function automatic logic [PW-1:0] inc_mod(input int x);
    if (x >= PORTS - 1) return '0;
    return PW'(x + 1);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_start) state_nxt = GRANT;
      GRANT:   state_nxt = ACCEPT;
      ACCEPT:  state_nxt = last_iter ? IDLE : GRANT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state != IDLE);
    fsm_state = state;
  end

  // Grant: each unmatched egress j offers itself to the first unmatched
  // requesting ingress at or after gptr[j]. grant bit [i*PORTS+j] = j grants i.
  always_comb begin : grant_search
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_nxt = '0;
    for (int j = 0; j < PORTS; j++) begin
      found = out_matched[j];
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(gptr[j]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!found && req[idx*PORTS+j] && !in_matched[idx]) begin
          grant_nxt[idx*PORTS+j] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Accept: each unmatched ingress takes the first granting egress at or
  // after aptr[i]. Each egress grants at most one ingress, so accepted pairs
  // never share an egress.
  always_comb begin : accept_search
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    accept  = '0;
    acc_in  = '0;
    acc_out = '0;
    for (int i = 0; i < PORTS; i++) begin
      found = in_matched[i];
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(aptr[i]) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!found && grant[i*PORTS+idx]) begin
          accept[i*PORTS+idx] = 1'b1;
          acc_in[i]           = 1'b1;
          acc_out[idx]        = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Datapath: snapshot, match accumulation, pointers and published result.
  // Reset anywhere in an epoch drops the epoch without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req         <= '0;
      grant       <= '0;
      match       <= '0;
      in_matched  <= '0;
      out_matched <= '0;
      iter        <= '0;
      sched_sel   <= '0;
      sched_done  <= 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        gptr[p] <= '0;
        aptr[p] <= '0;
      end
    end else begin
      sched_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sched_start) begin
            req         <= voq_nonempty;
            grant       <= '0;
            match       <= '0;
            in_matched  <= '0;
            out_matched <= '0;
            iter        <= '0;
          end
        end
        GRANT: grant <= grant_nxt;
        ACCEPT: begin
          match       <= match | accept;
          in_matched  <= in_matched | acc_in;
          out_matched <= out_matched | acc_out;
          // Pointers only move on first-iteration accepts; this is what
          // gives iSLIP its starvation freedom.
          if (iter == '0) begin
            for (int i = 0; i < PORTS; i++) begin
              for (int j = 0; j < PORTS; j++) begin
                if (accept[i*PORTS+j]) begin
                  aptr[i] <= inc_mod(j);
                  gptr[j] <= inc_mod(i);
                end
              end
            end
          end
          if (last_iter) begin
            sched_sel  <= match | accept;
            sched_done <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
